// File: rtl/cascade_stage_eval.sv
// Haar cascade stage sequencer: fetches each stage's threshold and vote count,
// accumulates the signed weak-classifier votes with saturation, and ends the
// window on the first failing stage or after the last stage passes.
module cascade_stage_eval #(
    parameter int unsigned W_DATA   = 11,
    parameter int unsigned W_ADDR   = 5,
    parameter int unsigned N_STAGES = 25,
    parameter int unsigned W_ACC    = 16,
    parameter int unsigned W_LEN    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              rom_en_o,
    output logic [W_ADDR-1:0] rom_addr_o,
    input  logic [W_DATA-1:0] stage_thr_i,
    input  logic [W_LEN-1:0]  stage_len_i,
    input  logic              vote_valid_i,
    input  logic [W_DATA-1:0] vote_i,
    output logic              vote_ready_o,
    output logic              done_o,
    output logic              detect_o,
    output logic [W_ADDR-1:0] fail_stage_o
);

    localparam logic [W_ADDR-1:0]       LAST_STAGE = W_ADDR'(N_STAGES - 1);
    localparam logic signed [W_ACC-1:0] ACC_MAX    = {1'b0, {(W_ACC-1){1'b1}}};
    localparam logic signed [W_ACC-1:0] ACC_MIN    = {1'b1, {(W_ACC-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ACCUM,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t                   state;
    logic [W_ADDR-1:0]        stage;
    logic signed [W_ACC-1:0]  acc;
    logic signed [W_ACC-1:0]  thr;
    logic [W_LEN-1:0]         len;
    logic [W_LEN-1:0]         count;

    logic                     hs_c;
    logic                     last_vote_c;
    logic                     pass_c;
    logic signed [W_ACC:0]    vote_ext_c;
    logic signed [W_ACC:0]    sum_c;
    logic signed [W_ACC-1:0]  acc_sat_c;

    assign rom_addr_o = stage;

    // Saturating vote sum, handshake and stage pass decode
    always_comb begin
        hs_c        = vote_valid_i && vote_ready_o;
        last_vote_c = (count == (len - W_LEN'(1)));
        pass_c      = (acc >= thr);
        vote_ext_c  = (W_ACC+1)'($signed(vote_i));
        sum_c       = (W_ACC+1)'(acc) + vote_ext_c;
        acc_sat_c   = W_ACC'(sum_c);
        if (sum_c[W_ACC] != sum_c[W_ACC-1]) begin
            acc_sat_c = sum_c[W_ACC] ? ACC_MIN : ACC_MAX;
        end
    end

    // Stage sequencing FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            stage        <= '0;
            acc          <= '0;
            thr          <= '0;
            len          <= '0;
            count        <= '0;
            busy_o       <= 1'b0;
            rom_en_o     <= 1'b0;
            vote_ready_o <= 1'b0;
            done_o       <= 1'b0;
            detect_o     <= 1'b0;
            fail_stage_o <= '0;
        end else begin
            rom_en_o <= 1'b0;
            done_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        detect_o     <= 1'b0;
                        fail_stage_o <= '0;
                        stage        <= '0;
                        rom_en_o     <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    thr   <= W_ACC'($signed(stage_thr_i));
                    len   <= stage_len_i;
                    acc   <= '0;
                    count <= '0;
                    if (stage_len_i != '0) begin
                        vote_ready_o <= 1'b1;
                        state        <= S_ACCUM;
                    end else begin
                        state <= S_COMPARE;
                    end
                end
                S_ACCUM: begin
                    if (hs_c) begin
                        acc   <= acc_sat_c;
                        count <= count + W_LEN'(1);
                        if (last_vote_c) begin
                            vote_ready_o <= 1'b0;
                            state        <= S_COMPARE;
                        end
                    end
                end
                S_COMPARE: begin
                    if (pass_c) begin
                        if (stage == LAST_STAGE) begin
                            detect_o     <= 1'b1;
                            fail_stage_o <= '0;
                            done_o       <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            stage    <= stage + W_ADDR'(1);
                            rom_en_o <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end else begin
                        detect_o     <= 1'b0;
                        fail_stage_o <= stage;
                        done_o       <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cascade_stage_eval.sv
// Directed bench for cascade_stage_eval: table of single-window vectors plus
// hand-written latency, full-cascade, restart and reset sequences. A second
// instance with a 12-bit accumulator exercises saturation.
module tb_cascade_stage_eval;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (default parameters)
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, rom_en, vote_ready, done, detect;
    logic [4:0]  rom_addr, fail_stage;
    logic [10:0] stage_thr = '0;
    logic [7:0]  stage_len = '0;
    logic        vote_valid = 1'b0;
    logic [10:0] vote = '0;

    cascade_stage_eval dut (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy),
        .rom_en_o(rom_en), .rom_addr_o(rom_addr),
        .stage_thr_i(stage_thr), .stage_len_i(stage_len),
        .vote_valid_i(vote_valid), .vote_i(vote), .vote_ready_o(vote_ready),
        .done_o(done), .detect_o(detect), .fail_stage_o(fail_stage)
    );

    // single-stage instance with a 12-bit accumulator
    logic        start2 = 1'b0;
    logic        busy2, rom_en2, vote_ready2, done2, detect2;
    logic [4:0]  rom_addr2, fail_stage2;
    logic [10:0] stage_thr2 = '0;
    logic [7:0]  stage_len2 = '0;
    logic        vote_valid2 = 1'b0;
    logic [10:0] vote2 = '0;

    cascade_stage_eval #(.N_STAGES(1), .W_ACC(12)) dut2 (
        .clk(clk), .rst(rst), .start_i(start2), .busy_o(busy2),
        .rom_en_o(rom_en2), .rom_addr_o(rom_addr2),
        .stage_thr_i(stage_thr2), .stage_len_i(stage_len2),
        .vote_valid_i(vote_valid2), .vote_i(vote2), .vote_ready_o(vote_ready2),
        .done_o(done2), .detect_o(detect2), .fail_stage_o(fail_stage2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // stage ROM model: one-cycle read latency
    logic [10:0] thr_mem [32];
    logic [7:0]  len_mem [32];
    always @(posedge clk) begin
        if (rom_en) begin
            stage_thr <= thr_mem[rom_addr];
            stage_len <= len_mem[rom_addr];
        end
    end

    // vote producer: presents queue head, pops after an accepted handshake
    int vq[$];
    bit throttle = 1'b0;
    bit hs_pend  = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            vq.delete();
            hs_pend    = 1'b0;
            vote_valid = 1'b0;
        end else begin
            if (hs_pend) void'(vq.pop_front());
            if (vq.size() > 0 && (!throttle || $urandom_range(0, 2) != 0)) begin
                vote_valid = 1'b1;
                vote       = 11'(vq[0]);
            end else begin
                vote_valid = 1'b0;
            end
            hs_pend = vote_valid && vote_ready;
        end
    end

    // output monitor
    int done_cnt = 0;
    int rom_cnt  = 0;
    int addr_log[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (rom_en) begin
                rom_cnt++;
                addr_log.push_back(int'(rom_addr));
            end
            if (done) done_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) begin
            thr_mem[i] = 11'(1);
            len_mem[i] = 8'd0;
        end
    endtask

    task automatic clear_counts();
        done_cnt = 0;
        rom_cnt  = 0;
        addr_log.delete();
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_seen"}, int'(done), 1);
    endtask

    // start one window, wait for its result, check busy/done drop next cycle
    task automatic run_window(input string nm);
        clear_counts();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nm);
        @(negedge clk);
        chk({nm, "_busy_drop"}, int'(busy), 0);
        cyc(2);
    endtask

    task automatic push_vote(input int v);
        vq.push_back(v);
    endtask

    // single stage on the 12-bit instance, votes fed one per handshake
    task automatic sat_run(input string nm, input int thr, input int len,
                           input int v0, input int v1, input int v2,
                           input int v3, input int v4, input int exp_det);
        int vv[5];
        int n;
        vv = '{v0, v1, v2, v3, v4};
        stage_thr2 = 11'(thr);
        stage_len2 = 8'(len);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < len; i++) begin
            vote2       = 11'(vv[i]);
            vote_valid2 = 1'b1;
            n = 0;
            while (!vote_ready2 && n < 100) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
        end
        vote_valid2 = 1'b0;
        n = 0;
        while (!done2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, int'(done2), 1);
        chk({nm, "_detect"}, int'(detect2), exp_det);
        chk({nm, "_fail_stage"}, int'(fail_stage2), 0);
        cyc(2);
    endtask

    typedef struct {
        int thr;
        int len;
        int v0, v1, v2, v3;
        int exp_fail;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int vv[4];
        int addr_bad;
        int n;

        // stage 0 from the row; stage 1 defaults to len=0 thr=1, which always fails
        tbl[0] = '{-514, 2, -300, -200, 0, 0, 1};
        tbl[1] = '{-514, 2, -300, -250, 0, 0, 0};
        tbl[2] = '{-514, 1, -514, 0, 0, 0, 1};
        tbl[3] = '{-514, 1, -515, 0, 0, 0, 0};
        tbl[4] = '{1, 0, 0, 0, 0, 0, 0};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 1};
        tbl[6] = '{1023, 4, 1023, 1023, 1023, -1, 1};
        tbl[7] = '{-1024, 4, -1024, -1024, -1024, -1024, 0};

        clear_rom();
        cyc(3);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rom_en", int'(rom_en), 0);
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_vote_ready", int'(vote_ready), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_detect", int'(detect), 0);
        chk("reset_fail_stage", int'(fail_stage), 0);
        rst = 1'b0;
        cyc(2);

        // cycle-accurate latency: start at t, rom_en t+1, ready t+3, next fetch t+6
        clear_rom();
        thr_mem[0] = 11'(-514);
        len_mem[0] = 8'd2;
        push_vote(-300);
        push_vote(-200);
        clear_counts();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lat_t1_rom_en", int'(rom_en), 1);
        chk("lat_t1_addr", int'(rom_addr), 0);
        chk("lat_t1_busy", int'(busy), 1);
        @(negedge clk);
        chk("lat_t2_rom_en", int'(rom_en), 0);
        chk("lat_t2_ready", int'(vote_ready), 0);
        @(negedge clk);
        chk("lat_t3_ready", int'(vote_ready), 1);
        @(negedge clk);
        chk("lat_t4_ready", int'(vote_ready), 1);
        @(negedge clk);
        chk("lat_t5_ready", int'(vote_ready), 0);
        chk("lat_t5_rom_en", int'(rom_en), 0);
        @(negedge clk);
        chk("lat_t6_rom_en", int'(rom_en), 1);
        chk("lat_t6_addr", int'(rom_addr), 1);
        cyc(3);
        chk("lat_t9_done", int'(done), 1);
        chk("lat_t9_detect", int'(detect), 0);
        chk("lat_t9_fail_stage", int'(fail_stage), 1);
        @(negedge clk);
        chk("lat_t10_done", int'(done), 0);
        chk("lat_t10_busy", int'(busy), 0);
        cyc(2);
        chk("lat_done_count", done_cnt, 1);

        // full cascade with throttled votes: every stage passes
        clear_rom();
        for (int s = 0; s < 25; s++) begin
            thr_mem[s] = 11'(-s);
            len_mem[s] = 8'(s % 4);
            for (int k = 0; k < s % 4; k++) push_vote(1);
        end
        throttle = 1'b1;
        run_window("full");
        throttle = 1'b0;
        chk("full_detect", int'(detect), 1);
        chk("full_fail_stage", int'(fail_stage), 0);
        chk("full_done_count", done_cnt, 1);
        chk("full_rom_count", rom_cnt, 25);
        addr_bad = 0;
        for (int s = 0; s < addr_log.size(); s++) if (addr_log[s] != s) addr_bad++;
        chk("full_addr_sequence_errors", addr_bad, 0);
        chk("full_votes_left", vq.size(), 0);

        // table of single-window vectors
        for (int i = 0; i < 8; i++) begin
            clear_rom();
            thr_mem[0] = 11'(tbl[i].thr);
            len_mem[0] = 8'(tbl[i].len);
            vv = '{tbl[i].v0, tbl[i].v1, tbl[i].v2, tbl[i].v3};
            for (int k = 0; k < tbl[i].len; k++) push_vote(vv[k]);
            run_window($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_detect", i), int'(detect), 0);
            chk($sformatf("vec%0d_fail_stage", i), int'(fail_stage), tbl[i].exp_fail);
            chk($sformatf("vec%0d_done_count", i), done_cnt, 1);
            chk($sformatf("vec%0d_rom_count", i), rom_cnt, tbl[i].exp_fail + 1);
            chk($sformatf("vec%0d_votes_left", i), vq.size(), 0);
        end

        // start pulsed during ACCUM is ignored
        clear_rom();
        thr_mem[0] = 11'(-514);
        len_mem[0] = 8'd2;
        clear_counts();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!vote_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accstart_ready_seen", int'(vote_ready), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc(2);
        push_vote(-300);
        push_vote(-200);
        wait_done("accstart");
        cyc(3);
        chk("accstart_fail_stage", int'(fail_stage), 1);
        chk("accstart_done_count", done_cnt, 1);
        chk("accstart_rom_count", rom_cnt, 2);

        // start held during DONE is ignored
        clear_rom();
        clear_counts();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("donestart");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("donestart_busy", int'(busy), 0);
        cyc(3);
        chk("donestart_busy_later", int'(busy), 0);
        chk("donestart_rom_count", rom_cnt, 1);

        // reset during ACCUM of stage 3
        clear_rom();
        for (int s = 0; s < 3; s++) begin
            thr_mem[s] = 11'(-10);
            len_mem[s] = 8'd1;
        end
        thr_mem[3] = 11'(-10);
        len_mem[3] = 8'd2;
        push_vote(0);
        push_vote(0);
        push_vote(0);
        push_vote(5);
        clear_counts();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(vote_ready && rom_addr == 5'd3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_stage3", int'(vote_ready && rom_addr == 5'd3), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_rom_en", int'(rom_en), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_vote_ready", int'(vote_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_detect", int'(detect), 0);
        chk("rst_fail_stage", int'(fail_stage), 0);
        cyc(3);
        rst = 1'b0;
        cyc(2);
        chk("rst_no_done", done_cnt, 0);
        clear_rom();
        thr_mem[0] = 11'(-514);
        len_mem[0] = 8'd2;
        push_vote(-300);
        push_vote(-250);
        run_window("after_rst");
        chk("after_rst_first_addr", (addr_log.size() > 0) ? addr_log[0] : -1, 0);
        chk("after_rst_fail_stage", int'(fail_stage), 0);
        chk("after_rst_done_count", done_cnt, 1);

        // saturation on the 12-bit accumulator, range [-2048, 2047]
        sat_run("sat_pos", 1023, 4, 1023, 1023, 1023, 1023, 0, 1);
        sat_run("sat_pos_back", 1023, 4, 1023, 1023, 1023, -1024, 0, 1);
        sat_run("sat_neg_back", -1024, 5, -1024, -1024, -1024, 1023, 1, 1);
        sat_run("sat_neg_fail", -1023, 5, -1024, -1024, -1024, 1023, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
